imem_sync_prog: RTL
===================

// Module: imem_sync_prog
// PURPOSE
//  Parametrised instruction memory for the pipelined MIPS core, replacing the combinational ROM.
//  Has a synchronous 1-cycle read into the IF/ID boundary, with stall-hold and flush-to-NOP.
//  Has a runtime programming port (debug/UART loader), so programs change without resynthesis.
//  Sits between the PC register and the IF/ID pipeline register.
// PARAMETERS
//  DATA_W    32       instruction width (bits)
//  ADDR_W    8        word-index width; DEPTH = 2**ADDR_W words
//  BASE_ADDR 32'h0    byte address of word 0 (must be aligned to DEPTH*4)
//  NOP_WORD  32'h0    word returned on flush, error or while not in RUN
//  CLEAR_ON_RESET 1   1: sweep-clear the RAM to NOP_WORD after reset; 0: keep contents
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-low reset
//  pc          in   32      fetch byte address
//  fetch_en    in   1       fetch request this cycle
//  stall       in   1       hold instr/instr_valid/addr_err unchanged
//  flush       in   1       next registered output is NOP_WORD, instr_valid=0
//  instr       out  DATA_W  registered instruction
//  instr_valid out  1       instr is a real fetched word
//  addr_err    out  1       registered: the fetch was misaligned or out of range
//  prog_req    in   1       level: request programming mode
//  prog_we     in   1       write strobe (honoured only in PROG)
//  prog_addr   in   ADDR_W  word index to write
//  prog_data   in   DATA_W  word to write
//  busy        out  1       1 in CLEAR or PROG (fetches are ignored)
// BEHAVIOUR
//  Reset (async assert, sync release): instr=NOP_WORD, instr_valid=0, addr_err=0.
//   State goes to CLEAR if CLEAR_ON_RESET, else RUN; sweep counter=0.
//  States: CLEAR, RUN, PROG.
//   CLEAR: writes NOP_WORD to word cnt each cycle; cnt++. At cnt==DEPTH-1 the write happens, then go to RUN.
//    Takes DEPTH cycles; busy=1. A prog_req during CLEAR is deferred until RUN.
//   RUN: prog_req=1 and stall=0 -> PROG next cycle. Otherwise serve fetches.
//   PROG: on each prog_we, mem[prog_addr]<=prog_data. prog_req=0 -> RUN next cycle.
//    Outputs held at NOP_WORD with instr_valid=0.
//  Fetch (RUN only), update priority flush > stall > fetch:
//   flush:     instr<=NOP_WORD, instr_valid<=0, addr_err<=0.
//   stall:     all three outputs hold.
//   fetch_en:  idx=(pc-BASE_ADDR)>>2. err = pc[1:0]!=0 or (pc-BASE_ADDR)>=DEPTH*4.
//    err=0 -> instr<=mem[idx], instr_valid<=1, addr_err<=0 (latency 1 cycle).
//    err=1 -> instr<=NOP_WORD, instr_valid<=0, addr_err<=1.
//   idle (fetch_en=0): instr<=NOP_WORD, instr_valid<=0, addr_err<=0.
//  Address arithmetic: 32-bit unsigned subtract. pc<BASE_ADDR wraps large -> out of range.
//  Read/write same word, same cycle: not possible (PROG and RUN are exclusive). The RAM is specified read-first anyway.
//  Reset mid-CLEAR or mid-PROG: aborts; a new sweep starts after release.
//   With CLEAR_ON_RESET=0, words already written are kept.
//  busy is combinational from state; no other output is combinational.
// STRUCTURE
//  mips_pkg: NOP_WORD default, imem_state_t {CLEAR,RUN,PROG} encoding.
//  Sub-module imem_sdp_ram: simple dual-port RAM, one write port, one registered read port.
//   Read-first; DATA_W/ADDR_W parameters; infers BRAM.
//  Top level: FSM, sweep counter, write-port mux (sweep vs prog), address check, output/valid registers.
// TESTING
//  1 Reset then CLEAR_ON_RESET=1: busy=1 for exactly 256 cycles; then fetch pc=0x0 -> instr=0x0, valid=1.
//  2 PROG: write idx0=0x24050000, idx1=0x24070200, drop prog_req.
//    Fetch pc=0x0,0x4 -> 0x24050000, 0x24070200, each 1 cycle after its pc.
//  3 Stall during fetch of pc=0x4: instr holds 0x24070200 across 3 stall cycles.
//    Flush with stall high -> instr=0x0, valid=0.
//  4 pc=0x2 -> addr_err=1, valid=0, instr=0x0. pc=0x400 (DEPTH=256) -> addr_err=1.
//    BASE_ADDR=0x00400000 with pc=0x003FFFFC -> addr_err=1.
//  5 prog_req asserted while stall=1: stays RUN until stall=0. prog_we in RUN is ignored (memory unchanged).
//  6 Assert reset at cnt=100 of CLEAR: outputs reset immediately. After release, full 256-cycle sweep restarts.

Source files
------------

// File: rtl/imem_sync_prog_pkg.sv
// Shared types and defaults for the synchronous, runtime-programmable instruction memory.
package imem_sync_prog_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IMEM_CLEAR = 2'd0,
        IMEM_RUN   = 2'd1,
        IMEM_PROG  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_sync_prog_if.sv
// Fetch and programming signals between the core/loader (master) and the instruction memory (slave).
interface imem_sync_prog_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [31:0]       pc;
    logic              fetch_en;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_err;
    logic              prog_req;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              busy;

    modport master (
        output pc, fetch_en, stall, flush, prog_req, prog_we, prog_addr, prog_data,
        input  instr, instr_valid, addr_err, busy
    );

    modport slave (
        input  pc, fetch_en, stall, flush, prog_req, prog_we, prog_addr, prog_data,
        output instr, instr_valid, addr_err, busy
    );
endinterface

// File: rtl/imem_sync_prog_sdp_ram.sv
// Simple dual-port RAM: one write port, one enabled registered read port, read-first.
module imem_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_sync_prog.sv
// Instruction memory between PC and IF/ID: 1-cycle synchronous fetch with stall/flush,
// power-up sweep clear, and a runtime programming port.
module imem_sync_prog
    import imem_sync_prog_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 8,
    parameter logic [31:0]       BASE_ADDR      = 32'h0,
    parameter logic [DATA_W-1:0] NOP_WORD       = DATA_W'(NOP_DEFAULT),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    imem_sync_prog_if.slave  bus
);
    imem_state_t       state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       off;
    logic              fetch_err;
    logic              serve;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;
    logic              err_p1;

    // BASE_ADDR is DEPTH*4 aligned, so off[1:0] equals pc[1:0] and wraps large when pc < BASE_ADDR.
    function automatic logic addr_fault(input logic [31:0] o);
        return (o[1:0] != 2'b00) || (o[31:ADDR_W+2] != '0);
    endfunction

    assign off       = bus.pc - BASE_ADDR;
    assign fetch_err = addr_fault(off);
    assign serve     = (state == IMEM_RUN) && !(bus.prog_req && !bus.stall);
    assign rd_en     = serve && !bus.flush && !bus.stall && bus.fetch_en && !fetch_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IMEM_CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = bus.prog_addr;
        wr_data   = bus.prog_data;
        case (state)
            IMEM_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = NOP_WORD;
                if (cnt == '1)
                    state_nxt = IMEM_RUN;
            end
            IMEM_RUN: begin
                if (bus.prog_req && !bus.stall)
                    state_nxt = IMEM_PROG;
            end
            IMEM_PROG: begin
                wr_en = bus.prog_we;
                if (!bus.prog_req)
                    state_nxt = IMEM_RUN;
            end
            default: state_nxt = IMEM_RUN;
        endcase
    end

    imem_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (off[ADDR_W+1:2]),
        .rdata (rd_data_p1)
    );

    // ---- stage p1: IF/ID boundary flags; the RAM read register holds data on stall ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (!serve || bus.flush) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (!bus.stall) begin
            vld_p1 <= bus.fetch_en && !fetch_err;
            err_p1 <= bus.fetch_en && fetch_err;
        end
    end

    // Gate the BRAM output register rather than re-registering it, keeping fetch latency at 1.
    assign bus.instr       = vld_p1 ? rd_data_p1 : NOP_WORD;
    assign bus.instr_valid = vld_p1;
    assign bus.addr_err    = err_p1;
    assign bus.busy        = (state != IMEM_RUN);
endmodule
